// File: rtl/fifo_stim_driver.sv
// -----------------------------------------------------------------------------
// fifo_stim_driver
//   Driving end of a FIFO self-test: resets the FIFO under test, then runs a
//   fixed FILL -> DRAIN -> MIXED stimulus sequence with LFSR data. While the
//   sequence runs it counts the FIFO's wr_ack / overflow / underflow responses.
//   All outputs are registered and change on posedge clk.
//
// Parameters
//   FIFO_WIDTH    data_in width (<= 16)
//   FIFO_DEPTH    depth of the FIFO under test; FILL and DRAIN each last
//                 FIFO_DEPTH+2 cycles, so each phase forces two over/underflows
//   MIXED_CYCLES  length of the random write/read phase
//   RST_CYCLES    cycles fifo_rst_n is held low per run (>= 1)
//   LFSR_SEED     seed used when the seed port is zero
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         start a run (only honoured in IDLE/DONE)
//   seed          LFSR seed, captured when start is accepted
//   wr_ack, overflow, underflow   FIFO responses to be counted
//   fifo_rst_n    active-low reset to the FIFO
//   data_in, wr_en, rd_en         FIFO stimulus
//   busy          high in RST_DUT/FILL/DRAIN/MIXED
//   done          high in DONE
//   phase         0 IDLE, 1 RST_DUT, 2 FILL, 3 DRAIN, 4 MIXED, 5 DONE
//   wr_ack_cnt, ovf_cnt, udf_cnt  saturating response counters
// -----------------------------------------------------------------------------
module fifo_stim_driver #(
  parameter int unsigned FIFO_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned MIXED_CYCLES = 64,
  parameter int unsigned RST_CYCLES   = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           seed,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  output logic                  fifo_rst_n,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            phase,
  output logic [15:0]           wr_ack_cnt,
  output logic [15:0]           ovf_cnt,
  output logic [15:0]           udf_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST_DUT = 3'd1,
    S_FILL    = 3'd2,
    S_DRAIN   = 3'd3,
    S_MIXED   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // The phase timer holds (length - 1) on entry and the phase ends when it
  // reads zero, so every phase lasts exactly its nominal length.
  localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
  localparam logic [15:0] FD_LOAD  = 16'(FIFO_DEPTH + 1);
  localparam logic [15:0] MIX_LOAD = 16'(MIXED_CYCLES - 1);

  state_t      state;
  logic [15:0] tmr;
  logic [15:0] lfsr;
  logic        done_first;
  logic        count_en;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic hit);
    return (hit && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  // The first DONE cycle still counts: the FIFO flags are registered, so the
  // response to the final MIXED stimulus cycle arrives one cycle late.
  always_comb begin
    count_en = 1'b0;
    case (state)
      S_FILL, S_DRAIN, S_MIXED: count_en = 1'b1;
      S_DONE:                   count_en = done_first;
      default:                  count_en = 1'b0;
    endcase
  end

  assign phase = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      lfsr       <= LFSR_SEED;
      done_first <= 1'b0;
      fifo_rst_n <= 1'b0;
      data_in    <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_ack_cnt <= '0;
      ovf_cnt    <= '0;
      udf_cnt    <= '0;
    end else begin
      done_first <= 1'b0;

      if (count_en) begin
        wr_ack_cnt <= sat_inc(wr_ack_cnt, wr_ack);
        ovf_cnt    <= sat_inc(ovf_cnt, overflow);
        udf_cnt    <= sat_inc(udf_cnt, underflow);
      end

      case (state)
        S_IDLE, S_DONE: begin
          fifo_rst_n <= 1'b1;
          wr_en      <= 1'b0;
          rd_en      <= 1'b0;
          if (start) begin
            state      <= S_RST_DUT;
            tmr        <= RST_LOAD;
            lfsr       <= (seed == 16'h0000) ? LFSR_SEED : seed;
            fifo_rst_n <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            // Clearing here overrides the first-DONE-cycle increment above.
            wr_ack_cnt <= '0;
            ovf_cnt    <= '0;
            udf_cnt    <= '0;
          end
        end

        S_RST_DUT: begin
          if (tmr == 16'd0) begin
            state      <= S_FILL;
            tmr        <= FD_LOAD;
            fifo_rst_n <= 1'b1;
            wr_en      <= 1'b1;
            rd_en      <= 1'b0;
            // First FILL word is the captured seed itself.
            data_in    <= lfsr[FIFO_WIDTH-1:0];
            lfsr       <= lfsr_step(lfsr);
          end else begin
            tmr <= tmr - 16'd1;
          end
        end

        S_FILL: begin
          data_in <= lfsr[FIFO_WIDTH-1:0];
          lfsr    <= lfsr_step(lfsr);
          if (tmr == 16'd0) begin
            state <= S_DRAIN;
            tmr   <= FD_LOAD;
            wr_en <= 1'b0;
            rd_en <= 1'b1;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end

        S_DRAIN: begin
          data_in <= lfsr[FIFO_WIDTH-1:0];
          lfsr    <= lfsr_step(lfsr);
          if (tmr == 16'd0) begin
            state <= S_MIXED;
            tmr   <= MIX_LOAD;
            wr_en <= lfsr[0];
            rd_en <= lfsr[1];
          end
          else begin
            tmr <= tmr - 16'd1;
          end
        end

        S_MIXED: begin
          if (tmr == 16'd0) begin
            // data_in and the LFSR hold from here on.
            state      <= S_DONE;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            done_first <= 1'b1;
          end else begin
            tmr     <= tmr - 16'd1;
            wr_en   <= lfsr[0];
            rd_en   <= lfsr[1];
            data_in <= lfsr[FIFO_WIDTH-1:0];
            lfsr    <= lfsr_step(lfsr);
          end
        end

        default: begin
          state <= S_IDLE;
          wr_en <= 1'b0;
          rd_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stim_driver.sv
module tb_fifo_stim_driver;

  localparam int R   = 2;
  localparam int D   = 8;
  localparam int M   = 64;
  localparam int RUN = 1 + R + 2 * (D + 2) + M;          // 87
  localparam int MS  = 65535;
  localparam int RUN_S = 1 + R + 2 * (D + 2) + MS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, start = 1'b0;
  logic [15:0] seed = '0;
  logic        wr_ack, overflow, underflow;
  logic        fifo_rst_n, wr_en, rd_en, busy, done;
  logic [15:0] data_in, wr_ack_cnt, ovf_cnt, udf_cnt;
  logic [2:0]  phase;

  logic        start_s = 1'b0;
  logic [15:0] seed_s = '0;
  logic        s_fifo_rst_n, s_wr_en, s_rd_en, s_busy, s_done;
  logic [15:0] s_data_in, s_wr_ack_cnt, s_ovf_cnt, s_udf_cnt;
  logic [2:0]  s_phase;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_stim_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .MIXED_CYCLES(M),
                     .RST_CYCLES(R), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .fifo_rst_n(fifo_rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .busy(busy), .done(done), .phase(phase),
    .wr_ack_cnt(wr_ack_cnt), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt));

  fifo_stim_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .MIXED_CYCLES(MS),
                     .RST_CYCLES(R), .LFSR_SEED(16'hACE1)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .seed(seed_s),
    .wr_ack(1'b1), .overflow(1'b1), .underflow(1'b1),
    .fifo_rst_n(s_fifo_rst_n), .data_in(s_data_in), .wr_en(s_wr_en), .rd_en(s_rd_en),
    .busy(s_busy), .done(s_done), .phase(s_phase),
    .wr_ack_cnt(s_wr_ack_cnt), .ovf_cnt(s_ovf_cnt), .udf_cnt(s_udf_cnt));

  // Behavioural depth-D FIFO with registered flags; also tallies every flag it raises.
  int unsigned stub_level = 0;
  int unsigned stub_ack = 0, stub_ovf = 0, stub_udf = 0;
  int unsigned base_ack, base_ovf, base_udf;

  always @(posedge clk) begin
    if (fifo_rst_n !== 1'b1) begin
      stub_level <= 0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ack     <= wr_en && (stub_level < D);
      overflow   <= wr_en && (stub_level >= D);
      underflow  <= rd_en && (stub_level == 0);
      stub_level <= stub_level + ((wr_en && stub_level < D) ? 1 : 0)
                                - ((rd_en && stub_level != 0) ? 1 : 0);
      if (wr_en && stub_level < D)  stub_ack <= stub_ack + 1;
      if (wr_en && stub_level >= D) stub_ovf <= stub_ovf + 1;
      if (rd_en && stub_level == 0) stub_udf <= stub_udf + 1;
    end
  end

  // Trace of one run, index k = cycle after the k-th edge following the start request.
  logic [2:0]  r_ph [256];
  logic        r_we [256], r_re [256], r_rn [256], r_busy [256], r_done [256];
  logic [15:0] r_di [256], r_ack [256], r_ovf [256], r_udf [256];
  int          done_at;

  logic [2:0]  e_ph [256];
  logic        e_we [256], e_re [256], e_rn [256];
  logic [15:0] e_di [256];

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    int   taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb = fb ^ v[taps[i] - 1];
    return {v[14:0], fb};
  endfunction

  task automatic build_expect(input logic [15:0] s);
    logic [15:0] cur;
    int idx;
    cur = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 1; k <= RUN; k++) begin
      if (k <= R) begin
        e_ph[k] = 3'd1; e_rn[k] = 1'b0; e_we[k] = 1'b0; e_re[k] = 1'b0; e_di[k] = '0;
      end else if (k < RUN) begin
        idx = k - R - 1;
        e_rn[k] = 1'b1;
        e_di[k] = cur;
        if (idx < D + 2) begin
          e_ph[k] = 3'd2; e_we[k] = 1'b1; e_re[k] = 1'b0;
        end else if (idx < 2 * (D + 2)) begin
          e_ph[k] = 3'd3; e_we[k] = 1'b0; e_re[k] = 1'b1;
        end else begin
          e_ph[k] = 3'd4; e_we[k] = cur[0]; e_re[k] = cur[1];
        end
        cur = ref_next(cur);
      end else begin
        e_ph[k] = 3'd5; e_rn[k] = 1'b1; e_we[k] = 1'b0; e_re[k] = 1'b0; e_di[k] = e_di[k-1];
      end
    end
  endtask

  // Caller is at a negedge; start is raised there and sampled at the next posedge.
  task automatic do_run(input logic [15:0] s, input int extra_start_at);
    seed = s;
    start = 1'b1;
    base_ack = stub_ack; base_ovf = stub_ovf; base_udf = stub_udf;
    done_at = -1;
    for (int k = 1; k <= 200 && done_at < 0; k++) begin
      @(negedge clk);
      start = (k == extra_start_at);
      r_ph[k] = phase; r_we[k] = wr_en; r_re[k] = rd_en; r_rn[k] = fifo_rst_n;
      r_busy[k] = busy; r_done[k] = done; r_di[k] = data_in;
      r_ack[k] = wr_ack_cnt; r_ovf[k] = ovf_cnt; r_udf[k] = udf_cnt;
      if (done === 1'b1) done_at = k;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; seed = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_checks++; if (fifo_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rst_n: got %b want 0", fifo_rst_n); end
    n_checks++; if ({wr_en, rd_en} !== 2'b00) begin n_fail++; $display("FAIL reset_enables: got %b want 00", {wr_en, rd_en}); end
    n_checks++; if (data_in !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data_in); end
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
    n_checks++; if ({wr_ack_cnt, ovf_cnt, udf_cnt} !== 48'h0) begin n_fail++;
      $display("FAIL reset_counters: got %h %h %h want 0", wr_ack_cnt, ovf_cnt, udf_cnt); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (fifo_rst_n !== 1'b1) begin n_fail++; $display("FAIL idle_fifo_rst_n: got %b want 1", fifo_rst_n); end
  endtask

  task automatic test_first_run();
    int n_wr;
    do_run(16'h0000, -1);
    n_checks++; if (done_at != RUN) begin n_fail++; $display("FAIL done_latency: got %0d want %0d", done_at, RUN); end
    n_checks++; if ({r_rn[1], r_rn[2], r_rn[3]} !== 3'b001) begin n_fail++;
      $display("FAIL dut_reset_width: got %b want 001", {r_rn[1], r_rn[2], r_rn[3]}); end
    n_wr = 0;
    for (int k = 1; k <= RUN; k++) if (r_we[k] === 1'b1 && r_ph[k] != 3'd4) n_wr++;
    n_checks++; if (n_wr != D + 2 || r_we[3] !== 1'b1 || r_we[3 + D + 1] !== 1'b1) begin n_fail++;
      $display("FAIL fill_length: got %0d want %0d", n_wr, D + 2); end
    n_checks++; if (r_di[3] !== 16'hACE1) begin n_fail++; $display("FAIL first_fill_data: got %h want ace1", r_di[3]); end
    n_checks++; if (r_ack[R + D + 4] !== 16'd8 || r_ovf[R + D + 4] !== 16'd2) begin n_fail++;
      $display("FAIL after_fill_counts: got ack %0d ovf %0d want 8 2", r_ack[R + D + 4], r_ovf[R + D + 4]); end
    n_checks++; if (r_udf[R + 2 * D + 6] !== 16'd2) begin n_fail++;
      $display("FAIL after_drain_udf: got %0d want 2", r_udf[R + 2 * D + 6]); end
    @(negedge clk);
    n_checks++; if (wr_ack_cnt !== 16'(stub_ack - base_ack) || ovf_cnt !== 16'(stub_ovf - base_ovf)
                    || udf_cnt !== 16'(stub_udf - base_udf)) begin n_fail++;
      $display("FAIL run_totals: got %0d %0d %0d want %0d %0d %0d", wr_ack_cnt, ovf_cnt, udf_cnt,
               stub_ack - base_ack, stub_ovf - base_ovf, stub_udf - base_udf); end
  endtask

  task automatic test_lfsr_trace();
    logic [15:0] s;
    logic [15:0] t_di [256];
    logic        t_we [256], t_re [256];
    int diffs;
    for (int run = 0; run < 5; run++) begin
      s = (run < 2) ? 16'h0001 : 16'($urandom);
      do_run(s, -1);
      build_expect(s);
      for (int k = 1; k <= RUN; k++) begin
        n_checks++;
        if (r_ph[k] !== e_ph[k] || r_we[k] !== e_we[k] || r_re[k] !== e_re[k] || r_rn[k] !== e_rn[k]
            || (k > R && r_di[k] !== e_di[k]) || r_busy[k] !== (k < RUN) || r_done[k] !== (k == RUN)) begin
          n_fail++;
          $display("FAIL trace seed %h k=%0d: got ph%0d we%b re%b rn%b di%h busy%b done%b want ph%0d we%b re%b rn%b di%h",
                   s, k, r_ph[k], r_we[k], r_re[k], r_rn[k], r_di[k], r_busy[k], r_done[k],
                   e_ph[k], e_we[k], e_re[k], e_rn[k], e_di[k]);
        end
      end
      if (run == 0) begin
        for (int k = 1; k <= RUN; k++) begin t_di[k] = r_di[k]; t_we[k] = r_we[k]; t_re[k] = r_re[k]; end
      end else if (run == 1) begin
        diffs = 0;
        for (int k = R + 1; k <= RUN; k++)
          if (t_di[k] !== r_di[k] || t_we[k] !== r_we[k] || t_re[k] !== r_re[k]) diffs++;
        n_checks++; if (diffs != 0) begin n_fail++; $display("FAIL same_seed_repeat: got %0d differing cycles want 0", diffs); end
      end
      @(negedge clk);
      n_checks++; if (wr_ack_cnt !== 16'(stub_ack - base_ack) || ovf_cnt !== 16'(stub_ovf - base_ovf)
                      || udf_cnt !== 16'(stub_udf - base_udf)) begin n_fail++;
        $display("FAIL counts seed %h: got %0d %0d %0d want %0d %0d %0d", s, wr_ack_cnt, ovf_cnt, udf_cnt,
                 stub_ack - base_ack, stub_ovf - base_ovf, stub_udf - base_udf); end
    end
  endtask

  task automatic test_reset_mid_run();
    seed = 16'($urandom);
    start = 1'b1;
    for (int k = 1; k <= R + 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++; if (phase !== 3'd2 || wr_ack_cnt == 16'd0) begin n_fail++;
      $display("FAIL mid_fill_precondition: got phase %0d ack %0d want 2 nonzero", phase, wr_ack_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL midrst_phase: got %0d want 0", phase); end
    n_checks++; if ({wr_en, rd_en, busy, done} !== 4'b0000) begin n_fail++;
      $display("FAIL midrst_outputs: got %b want 0000", {wr_en, rd_en, busy, done}); end
    n_checks++; if ({wr_ack_cnt, ovf_cnt, udf_cnt} !== 48'h0) begin n_fail++;
      $display("FAIL midrst_counters: got %h %h %h want 0", wr_ack_cnt, ovf_cnt, udf_cnt); end
    n_checks++; if (fifo_rst_n !== 1'b0 || data_in !== 16'h0000) begin n_fail++;
      $display("FAIL midrst_rst_n_data: got %b %h want 0 0000", fifo_rst_n, data_in); end
    @(negedge clk);
    n_checks++; if (fifo_rst_n !== 1'b1 || phase !== 3'd0) begin n_fail++;
      $display("FAIL midrst_release: got rst_n %b phase %0d want 1 0", fifo_rst_n, phase); end
  endtask

  task automatic test_start_ignored();
    int bad;
    logic [15:0] s;
    s = 16'($urandom);
    do_run(s, R + D + 5);
    build_expect(s);
    n_checks++; if (done_at != RUN) begin n_fail++; $display("FAIL drain_start_latency: got %0d want %0d", done_at, RUN); end
    bad = 0;
    for (int k = 1; k <= RUN; k++) if (r_ph[k] !== e_ph[k]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drain_start_phases: got %0d wrong cycles want 0", bad); end
    n_checks++; if (wr_ack_cnt == 16'd0) begin n_fail++; $display("FAIL done_counts_nonzero: got 0 want nonzero"); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (phase !== 3'd1 || busy !== 1'b1 || done !== 1'b0) begin n_fail++;
      $display("FAIL restart_from_done: got phase %0d busy %b done %b want 1 1 0", phase, busy, done); end
    n_checks++; if ({wr_ack_cnt, ovf_cnt, udf_cnt} !== 48'h0) begin n_fail++;
      $display("FAIL restart_counters: got %h %h %h want 0", wr_ack_cnt, ovf_cnt, udf_cnt); end
    bad = 0;
    for (int k = 0; k < 200 && done !== 1'b1; k++) begin @(negedge clk); bad = k + 2; end
    n_checks++; if (done !== 1'b1 || bad != RUN) begin n_fail++;
      $display("FAIL restart_done: got done %b at %0d want 1 at %0d", done, bad, RUN); end
  endtask

  task automatic test_saturate();
    int at, wraps;
    logic [15:0] prev;
    seed_s = 16'($urandom);
    start_s = 1'b1;
    at = -1; wraps = 0; prev = '0;
    for (int k = 1; k <= 70000 && at < 0; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (s_wr_ack_cnt < prev || s_udf_cnt < prev) wraps++;
      prev = s_wr_ack_cnt;
      if (s_done === 1'b1) at = k;
    end
    n_checks++; if (at != RUN_S) begin n_fail++; $display("FAIL sat_done_latency: got %0d want %0d", at, RUN_S); end
    @(negedge clk);
    n_checks++; if ({s_wr_ack_cnt, s_ovf_cnt, s_udf_cnt} !== {3{16'hFFFF}}) begin n_fail++;
      $display("FAIL sat_value: got %h %h %h want ffff", s_wr_ack_cnt, s_ovf_cnt, s_udf_cnt); end
    repeat (3) @(negedge clk);
    n_checks++; if (s_wr_ack_cnt !== 16'hFFFF || wraps != 0) begin n_fail++;
      $display("FAIL sat_no_wrap: got %h with %0d drops want ffff 0", s_wr_ack_cnt, wraps); end
  endtask

  initial begin
    test_reset();
    test_first_run();
    test_lfsr_trace();
    @(negedge clk);
    test_reset_mid_run();
    @(negedge clk);
    test_start_ignored();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
